// File: rtl/xlmc_opi_seq.sv
// Xccela/OPI PSRAM transaction sequencer: drives registered ODDR/tristate pin inputs per phase.
// Optional build macro XLMC_WR_DM_EN drives DM from the write strobes during write data.
module xlmc_opi_seq #(
  parameter int LEN_W          = 8,
  parameter int LAT_W          = 5,
  parameter int CE_HIGH_CYCLES = 2
) (
  input  logic             oddr_clk,
  input  logic             arst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_inst,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [LAT_W-1:0] cfg_latency,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      wr_data,
  input  logic [1:0]       wr_strb,
  output logic [7:0]       dq_d1,
  output logic [7:0]       dq_d2,
  output logic             dq_t,
  output logic             dm_d1,
  output logic             dm_d2,
  output logic             dm_t,
  output logic             ce_n,
  output logic             ck_en,
  output logic             rd_window,
  output logic             busy,
  output logic             done
);
  localparam int CW = LEN_W + 1;
  localparam int EW = $clog2(CE_HIGH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR0, S_ADDR1, S_LAT, S_WDATA, S_RDATA, S_END
  } state_t;

  state_t           state, state_d, data_st;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LAT_W-1:0] lcnt, lcnt_d;
  logic [CW-1:0]    wcnt, wcnt_d, n_words;
  logic [EW-1:0]    ecnt, ecnt_d;
  logic             last_pre, wr_hs;
  logic [7:0]       dq_d1_d, dq_d2_d;
  logic             dq_t_d, dm_d1_d, dm_d2_d, dm_t_d, ce_n_d, ck_en_d, rd_d, done_d;

`ifndef XLMC_WR_DM_EN
  logic strb_unused;
  assign strb_unused = ^wr_strb;
`endif

  // wcnt counts words accepted (write) or read cycles issued; CW bits so 256 words don't wrap
  assign n_words   = {1'b0, len_q} + CW'(1);
  assign data_st   = wr_q ? S_WDATA : S_RDATA;
  assign last_pre  = (state == S_ADDR1 && lcnt == '0) || (state == S_LAT && lcnt == LAT_W'(1));
  assign wr_ready  = wr_q && (last_pre || state == S_WDATA) && (wcnt < n_words);
  assign wr_hs     = wr_valid && wr_ready;
  assign cmd_ready = (state == S_IDLE) && !arst;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_d = state;
    lcnt_d  = lcnt;
    wcnt_d  = wcnt;
    ecnt_d  = ecnt;
    case (state)
      S_IDLE: if (cmd_valid) begin
        state_d = S_CMD;
        lcnt_d  = cfg_latency;
        wcnt_d  = '0;
      end
      S_CMD:   state_d = S_ADDR0;
      S_ADDR0: state_d = S_ADDR1;
      S_ADDR1: state_d = (lcnt == '0) ? data_st : S_LAT;
      S_LAT: begin
        lcnt_d = lcnt - LAT_W'(1);
        if (lcnt == LAT_W'(1)) state_d = data_st;
      end
      S_WDATA, S_RDATA: if (wcnt == n_words) begin
        state_d = S_END;
        ecnt_d  = EW'(1);
      end
      S_END: begin
        ecnt_d = ecnt + EW'(1);
        if (ecnt == EW'(CE_HIGH_CYCLES)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_hs || state_d == S_RDATA) wcnt_d = wcnt + CW'(1);
  end

  // Pin values are computed for the upcoming state so every output is a flop
  always_comb begin
    ce_n_d  = (state_d == S_IDLE) || (state_d == S_END);
    ck_en_d = 1'b0;
    dq_t_d  = 1'b1;
    dq_d1_d = '0;
    dq_d2_d = '0;
    dm_t_d  = 1'b1;
    dm_d1_d = 1'b0;
    dm_d2_d = 1'b0;
    rd_d    = 1'b0;
    done_d  = (state_d == S_END) && (state != S_END);
    case (state_d)
      S_CMD:   begin ck_en_d = 1'b1; dq_t_d = 1'b0; dq_d1_d = cmd_inst;      dq_d2_d = cmd_inst;      end
      S_ADDR0: begin ck_en_d = 1'b1; dq_t_d = 1'b0; dq_d1_d = addr_q[31:24]; dq_d2_d = addr_q[23:16]; end
      S_ADDR1: begin ck_en_d = 1'b1; dq_t_d = 1'b0; dq_d1_d = addr_q[15:8];  dq_d2_d = addr_q[7:0];   end
      S_LAT:   begin ck_en_d = 1'b1; dq_t_d = !wr_q; end
      S_WDATA: begin
        dq_t_d  = 1'b0;
        ck_en_d = wr_hs;
        if (wr_hs) begin
          dq_d1_d = wr_data[15:8];
          dq_d2_d = wr_data[7:0];
          dm_t_d  = 1'b0;
`ifdef XLMC_WR_DM_EN
          dm_d1_d = ~wr_strb[1];
          dm_d2_d = ~wr_strb[0];
`endif
        end else begin
          // stall: CK parked, pins hold the last driven word
          dq_d1_d = dq_d1;
          dq_d2_d = dq_d2;
          dm_t_d  = dm_t;
          dm_d1_d = dm_d1;
          dm_d2_d = dm_d2;
        end
      end
      S_RDATA: begin ck_en_d = 1'b1; rd_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge oddr_clk) begin
    if (arst) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      lcnt      <= '0;
      wcnt      <= '0;
      ecnt      <= '0;
      ce_n      <= 1'b1;
      ck_en     <= 1'b0;
      dq_t      <= 1'b1;
      dq_d1     <= '0;
      dq_d2     <= '0;
      dm_t      <= 1'b1;
      dm_d1     <= 1'b0;
      dm_d2     <= 1'b0;
      rd_window <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        wr_q   <= cmd_write;
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
      end
      state     <= state_d;
      lcnt      <= lcnt_d;
      wcnt      <= wcnt_d;
      ecnt      <= ecnt_d;
      ce_n      <= ce_n_d;
      ck_en     <= ck_en_d;
      dq_t      <= dq_t_d;
      dq_d1     <= dq_d1_d;
      dq_d2     <= dq_d2_d;
      dm_t      <= dm_t_d;
      dm_d1     <= dm_d1_d;
      dm_d2     <= dm_d2_d;
      rd_window <= rd_d;
      done      <= done_d;
    end
  end
endmodule

// File: tb/tb_xlmc_opi_seq.sv
// Scoreboard bench for xlmc_opi_seq: per-cycle pin vectors predicted from the phase rules.
module tb_xlmc_opi_seq;
  localparam int LEN_W = 8;
  localparam int LAT_W = 5;
  localparam int CEH   = 2;

  logic             clk = 1'b0;
  logic             arst;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [7:0]       cmd_inst;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [LAT_W-1:0] cfg_latency;
  logic             wr_valid, wr_ready;
  logic [15:0]      wr_data;
  logic [1:0]       wr_strb;
  logic [7:0]       dq_d1, dq_d2;
  logic             dq_t, dm_d1, dm_d2, dm_t, ce_n, ck_en, rd_window, busy, done;

  always #5 clk = ~clk;

  xlmc_opi_seq #(.LEN_W(LEN_W), .LAT_W(LAT_W), .CE_HIGH_CYCLES(CEH)) dut (
    .oddr_clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_inst(cmd_inst), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cfg_latency(cfg_latency),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .dq_d1(dq_d1), .dq_d2(dq_d2), .dq_t(dq_t), .dm_d1(dm_d1), .dm_d2(dm_d2), .dm_t(dm_t),
    .ce_n(ce_n), .ck_en(ck_en), .rd_window(rd_window), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic ce_n, ck_en, dq_t;
    logic [7:0] d1, d2;
    logic dm_t, dm1, dm2, rd, done, busy, wrr;
  } pin_t;

  pin_t        expq[$];
  int          total = 0, bad = 0;
  bit          mon_en = 1'b0;
  bit          vld [0:1023];
  logic [15:0] words [0:511];
  logic [1:0]  strbs [0:511];

  function automatic pin_t mk(logic c, logic k, logic t, logic [7:0] a, logic [7:0] b,
                              logic mt, logic m1, logic m2, logic r, logic dn, logic bz, logic wr);
    return {c, k, t, a, b, mt, m1, m2, r, dn, bz, wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every busy cycle must match the next predicted pin vector
  initial begin
    pin_t a, e;
    forever begin
      @(negedge clk);
      if (mon_en && busy) begin
        a = {ce_n, ck_en, dq_t, dq_d1, dq_d2, dm_t, dm_d1, dm_d2, rd_window, done, busy, wr_ready};
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL pins_extra act=%h exp=none at %0t", a, $time);
        end else begin
          e = expq.pop_front();
          if (e.dq_t) begin a.d1 = '0; a.d2 = '0; e.d1 = '0; e.d2 = '0; end
          if (a !== e) begin
            bad++;
            $display("FAIL pins act=%h exp=%h at %0t", a, e, $time);
          end
        end
      end
    end
  end

  task automatic fill(input bit dense);
    for (int i = 0; i < 1024; i++) vld[i] = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 512; i++) begin
      words[i] = 16'($urandom);
      strbs[i] = 2'($urandom);
    end
  endtask

  // Reference: cycle k after accept (k=0) -> expected pins, from the phase rules
  task automatic build(input bit wr, input logic [7:0] inst, input logic [31:0] addr,
                       input int n, input int l, output int d);
    logic [7:0] h1, h2;
    logic       hmt, hm1, hm2;
    int acc, k;
    bit prev, fin;
    expq.push_back(mk(0, 1, 0, inst, inst, 1, 0, 0, 0, 0, 1, 0));
    expq.push_back(mk(0, 1, 0, addr[31:24], addr[23:16], 1, 0, 0, 0, 0, 1, 0));
    expq.push_back(mk(0, 1, 0, addr[15:8], addr[7:0], 1, 0, 0, 0, 0, 1, wr && l == 0));
    for (int c = 4; c <= 3 + l; c++)
      expq.push_back(mk(0, 1, !wr, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, wr && c == 3 + l));
    if (wr) begin
      h1 = 0; h2 = 0; hmt = 1; hm1 = 0; hm2 = 0;
      prev = vld[3 + l];
      acc = prev ? 1 : 0;
      k = 4 + l;
      fin = 0;
      d = 0;
      while (!fin) begin
        if (prev) begin
          h1 = words[acc-1][15:8];
          h2 = words[acc-1][7:0];
          hmt = 0;
`ifdef XLMC_WR_DM_EN
          hm1 = !strbs[acc-1][1];
          hm2 = !strbs[acc-1][0];
`else
          hm1 = 0;
          hm2 = 0;
`endif
        end
        if (prev && acc == n) begin
          expq.push_back(mk(0, 1, 0, h1, h2, hmt, hm1, hm2, 0, 0, 1, 0));
          d = k;
          fin = 1;
        end else begin
          expq.push_back(mk(0, prev, 0, h1, h2, hmt, hm1, hm2, 0, 0, 1, 1));
          prev = vld[k];
          acc += prev ? 1 : 0;
          k++;
        end
      end
    end else begin
      for (int c = 0; c < n; c++) expq.push_back(mk(0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 1, 0, 1, 0));
      d = 3 + l + n;
    end
    expq.push_back(mk(1, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 1, 1, 0));
    for (int c = 1; c < CEH; c++) expq.push_back(mk(1, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 0));
  endtask

  task automatic run(input bit wr, input logic [7:0] inst, input logic [31:0] addr,
                     input int len, input int l, input bit junk);
    int d, t, hs_cnt;
    bit hs;
    build(wr, inst, addr, len + 1, l, d);
    t = d + CEH;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_inst = inst; cmd_addr = addr;
    cmd_len = LEN_W'(len); cfg_latency = LAT_W'(l); wr_valid = 0;
    @(negedge clk);
    chk("cmd_ready_accept", cmd_ready, 1);
    @(posedge clk); #1;
    hs_cnt = 0;
    for (int k = 1; k <= t; k++) begin
      cmd_valid = (junk && k < t) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        cmd_write = 1'($urandom); cmd_inst = 8'($urandom); cmd_addr = $urandom;
        cmd_len = LEN_W'($urandom); cfg_latency = LAT_W'($urandom);
      end
      wr_valid = vld[k];
      wr_data  = words[hs_cnt];
      wr_strb  = strbs[hs_cnt];
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (hs) hs_cnt++;
    end
    cmd_valid = 0;
    wr_valid = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("idle_ce_n", ce_n, 1);
    chk("words_accepted", hs_cnt, wr ? len + 1 : 0);
    chk("queue_drained", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    bit seen;
    arst = 1; cmd_valid = 0; cmd_write = 0; cmd_inst = 0; cmd_addr = 0; cmd_len = 0;
    cfg_latency = 0; wr_valid = 0; wr_data = 0; wr_strb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pins", {ce_n, ck_en, dq_t, dm_t, dq_d1, dq_d2, dm_d1, dm_d2},
        {1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    chk("rst_flags", {wr_ready, rd_window, done, busy}, 4'b0000);
    @(posedge clk); #1;
    arst = 0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);
    mon_en = 1;

    fill(1);
    run(1, 8'hA0, 32'h12345678, 3, 3, 0);
    fill(1);
    vld[7] = 0; vld[8] = 0;
    run(1, 8'hA0, 32'h12345678, 3, 3, 0);
    fill(1);
    run(0, 8'h20, $urandom, 0, 0, 0);
    fill(0);
    run(1, 8'hA0, $urandom, 0, 0, 0);
    run(0, 8'h20, $urandom, 255, 2, 0);

    // abort a read in its latency phase
    mon_en = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_inst = 8'h20; cmd_addr = $urandom; cmd_len = 3; cfg_latency = 5;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_busy", {busy, ck_en, dq_t, ce_n}, 4'b1110);
    arst = 1;
    @(posedge clk); #1;
    arst = 0;
    @(negedge clk);
    chk("abort_pins", {busy, ce_n, dq_t, dm_t, ck_en, rd_window, done, wr_ready}, 8'b01110000);
    chk("abort_cmd_ready", cmd_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    mon_en = 1;

    for (int i = 0; i < 20; i++) begin
      fill(0);
      run(1'($urandom), 8'($urandom), $urandom, $urandom_range(0, 15), $urandom_range(0, 7), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
